// File: rtl/sdram_target.sv
`default_nettype none
// ============================================================================
// sdram_target
//   Single-clock SDRAM device model: decodes commands, tracks open rows,
//   serves reads/writes from an internal array and latches the first
//   protocol or timing violation.
// Revision: 1.0
// ============================================================================
module sdram_target #(
  parameter int BANKBITS  = 1,
  parameter int ROWBITS   = 11,
  parameter int COLBITS   = 8,
  parameter int DWIDTH    = 16,
  parameter int MEMBITS   = 12,
  parameter int T_RC      = 8,
  parameter int T_RCD     = 3,
  parameter int T_RP      = 3,
  parameter int T_WR      = 2,
  parameter int T_MRD     = 3,
  parameter int T_REF_MAX = 2048
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sdram_ras_n,
  input  logic                         sdram_cas_n,
  input  logic                         sdram_we_n,
  input  logic [BANKBITS+ROWBITS-1:0]  sdram_addr,
  input  logic [DWIDTH-1:0]            sdram_dq_i,
  input  logic                         sdram_dq_oe_i,
  output logic [DWIDTH-1:0]            sdram_dq_o,
  output logic                         sdram_dq_oe,
  output logic                         init_done,
  output logic                         err,
  output logic [3:0]                   err_code
);

  localparam int NB    = 1 << BANKBITS;
  localparam int IDXW  = ROWBITS + BANKBITS + COLBITS;
  localparam int CSPAN = T_REF_MAX + T_RC + T_RCD + T_RP + T_WR + T_MRD + 2;
  localparam int CW    = $clog2(CSPAN) + 1;

  localparam logic [CW-1:0] C_MAX     = '1;
  localparam logic [CW-1:0] C_ONE     = CW'(1);
  localparam logic [CW-1:0] C_RC      = CW'(T_RC);
  localparam logic [CW-1:0] C_RCD     = CW'(T_RCD);
  localparam logic [CW-1:0] C_WR      = CW'(T_WR);
  localparam logic [CW-1:0] C_MRD     = CW'(T_MRD);
  localparam logic [CW-1:0] C_REF_MAX = CW'(T_REF_MAX);
  // tRP counters carry a +T_WR bias so an auto-precharge WRITE can start "in the past"
  localparam logic [CW-1:0] C_RP_CHK  = CW'(T_RP + T_WR);
  localparam logic [CW-1:0] C_PRE_LD  = CW'(1 + T_WR);

  localparam logic [2:0] CMD_MRS = 3'b000;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_RD  = 3'b101;

  logic [2:0]          w_cmd;
  logic [BANKBITS-1:0] w_bank;
  logic [ROWBITS-1:0]  w_low;
  logic [COLBITS-1:0]  w_col;
  logic                w_a10;
  logic w_is_mrs, w_is_ref, w_is_pre, w_is_act, w_is_wr, w_is_rd, w_is_cmd;
  logic w_mode_ok, w_any_open, w_rp_all_ok, w_wr_ok;
  logic w_bad, w_ok, w_act_opens, w_rd_go, w_wr_go;
  logic [10:1] w_viol;
  logic [3:0]  w_code;

  logic [NB-1:0]       open_q, open_d;
  logic [ROWBITS-1:0]  row_q [NB];
  logic [ROWBITS-1:0]  row_d [NB];
  logic [CW-1:0]       rcd_q [NB];
  logic [CW-1:0]       rcd_d [NB];
  logic [CW-1:0]       rp_q  [NB];
  logic [CW-1:0]       rp_d  [NB];
  logic [CW-1:0]       wr_q  [NB];
  logic [CW-1:0]       wr_d  [NB];
  logic [CW-1:0]       rc_q, rc_d, mrd_q, mrd_d, gap_q, gap_d;
  logic                mode_set_q, mode_set_d, cl3_q, cl3_d;
  logic [1:0]          nref_q, nref_d;
  logic                init_done_q, init_done_d, err_q, err_d;
  logic [3:0]          code_q, code_d;

  logic [IDXW-1:0]     w_full_idx;
  logic [MEMBITS-1:0]  w_idx;
  logic [DWIDTH-1:0]   mem [2**MEMBITS];
  logic                s1_vld_q, s2_vld_q, dq_oe_q, w_out_vld;
  logic [DWIDTH-1:0]   s1_data_q, s2_data_q, dq_q, w_out_data;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == C_MAX) ? v : v + C_ONE;
  endfunction

  assign w_cmd    = {sdram_ras_n, sdram_cas_n, sdram_we_n};
  assign w_bank   = sdram_addr[BANKBITS+ROWBITS-1:ROWBITS];
  assign w_low    = sdram_addr[ROWBITS-1:0];
  assign w_col    = w_low[COLBITS-1:0];
  assign w_a10    = w_low[10];
  assign w_is_mrs = (w_cmd == CMD_MRS);
  assign w_is_ref = (w_cmd == CMD_REF);
  assign w_is_pre = (w_cmd == CMD_PRE);
  assign w_is_act = (w_cmd == CMD_ACT);
  assign w_is_wr  = (w_cmd == CMD_WR);
  assign w_is_rd  = (w_cmd == CMD_RD);
  assign w_is_cmd = ~(w_cmd[2] & w_cmd[1]);
  assign w_mode_ok  = w_low[5] && (w_low[2:0] == 3'b000);
  assign w_any_open = |open_q;

  assign w_full_idx = {row_q[w_bank], w_bank, w_col};
  generate
    if (MEMBITS < IDXW) begin : g_alias
      logic unused_idx_hi;
      assign unused_idx_hi = ^w_full_idx[IDXW-1:MEMBITS];
      assign w_idx = w_full_idx[MEMBITS-1:0];
    end else begin : g_full
      assign w_idx = MEMBITS'(w_full_idx);
    end
  endgenerate

  always_comb begin
    w_rp_all_ok = 1'b1;
    w_wr_ok     = 1'b1;
    for (int b = 0; b < NB; b++) begin
      if (rp_q[b] < C_RP_CHK) w_rp_all_ok = 1'b0;
      if ((w_a10 || (w_bank == BANKBITS'(b))) && (wr_q[b] < C_WR)) w_wr_ok = 1'b0;
    end
  end

  always_comb begin
    w_viol     = '0;
    w_viol[1]  = (w_is_act | w_is_rd | w_is_wr) & ~init_done_q;
    w_viol[2]  = (w_is_act & open_q[w_bank]) | ((w_is_rd | w_is_wr) & ~open_q[w_bank])
               | ((w_is_ref | w_is_mrs) & w_any_open);
    w_viol[3]  = (w_is_rd | w_is_wr) & (rcd_q[w_bank] < C_RCD);
    w_viol[4]  = (w_is_act & (rp_q[w_bank] < C_RP_CHK)) | (w_is_ref & ~w_rp_all_ok);
    w_viol[5]  = (w_is_act | w_is_ref) & (rc_q < C_RC);
    w_viol[6]  = w_is_cmd & (mrd_q < C_MRD);
    w_viol[7]  = w_is_pre & ~w_wr_ok;
    w_viol[8]  = init_done_q & (gap_q > C_REF_MAX);
    w_viol[9]  = sdram_dq_oe_i & dq_oe_q;
    w_viol[10] = w_is_mrs & ~w_mode_ok;
    w_code = 4'd0;
    for (int i = 10; i >= 1; i--) begin
      if (w_viol[i]) w_code = 4'(i);
    end
  end

  // Refresh-gap and bus-contention faults do not make the current command illegal
  assign w_bad       = (|w_viol[7:1]) | w_viol[10];
  assign w_ok        = ~w_bad;
  assign w_act_opens = w_is_act & ~w_viol[1] & ~w_viol[2] & ~w_viol[6];
  assign w_rd_go     = w_ok & w_is_rd;
  assign w_wr_go     = w_ok & w_is_wr;

  always_comb begin
    open_d = open_q;
    for (int b = 0; b < NB; b++) begin
      row_d[b] = row_q[b];
      rcd_d[b] = sat_inc(rcd_q[b]);
      rp_d[b]  = sat_inc(rp_q[b]);
      wr_d[b]  = sat_inc(wr_q[b]);
      if (w_act_opens && (w_bank == BANKBITS'(b))) begin
        open_d[b] = 1'b1;
        row_d[b]  = w_low;
        rcd_d[b]  = C_ONE;
      end
      if (w_ok && w_is_pre && (w_a10 || (w_bank == BANKBITS'(b)))) begin
        open_d[b] = 1'b0;
        rp_d[b]   = C_PRE_LD;
      end
      if (w_ok && (w_is_rd || w_is_wr) && (w_bank == BANKBITS'(b))) begin
        if (w_is_wr) wr_d[b] = C_ONE;
        if (w_a10) begin
          open_d[b] = 1'b0;
          rp_d[b]   = w_is_wr ? C_ONE : C_PRE_LD;
        end
      end
    end
  end

  always_comb begin
    rc_d        = sat_inc(rc_q);
    mrd_d       = sat_inc(mrd_q);
    gap_d       = sat_inc(gap_q);
    mode_set_d  = mode_set_q;
    cl3_d       = cl3_q;
    nref_d      = nref_q;
    init_done_d = init_done_q | (nref_q == 2'd2);
    err_d       = err_q;
    code_d      = code_q;
    if (w_ok && w_is_ref) begin
      rc_d  = C_ONE;
      gap_d = C_ONE;
      if (mode_set_q && (nref_q != 2'd2)) nref_d = nref_q + 2'd1;
    end
    if (w_ok && w_is_mrs) begin
      mrd_d      = C_ONE;
      mode_set_d = 1'b1;
      cl3_d      = w_low[4];
      nref_d     = 2'd0;
    end
    if (!err_q && (|w_viol)) begin
      err_d  = 1'b1;
      code_d = w_code;
    end
  end

  assign w_out_vld  = cl3_q ? s2_vld_q  : s1_vld_q;
  assign w_out_data = cl3_q ? s2_data_q : s1_data_q;

  always_ff @(posedge clk) begin
    if (w_wr_go) mem[w_idx] <= sdram_dq_i;
    s1_data_q <= mem[w_idx];
    s2_data_q <= s1_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      open_q      <= '0;
      for (int b = 0; b < NB; b++) begin
        row_q[b] <= '0;
        rcd_q[b] <= C_MAX;
        rp_q[b]  <= C_MAX;
        wr_q[b]  <= C_MAX;
      end
      rc_q        <= C_MAX;
      mrd_q       <= C_MAX;
      gap_q       <= '0;
      mode_set_q  <= 1'b0;
      cl3_q       <= 1'b0;
      nref_q      <= 2'd0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= 4'd0;
      s1_vld_q    <= 1'b0;
      s2_vld_q    <= 1'b0;
      dq_oe_q     <= 1'b0;
      dq_q        <= '0;
    end else begin
      open_q      <= open_d;
      row_q       <= row_d;
      rcd_q       <= rcd_d;
      rp_q        <= rp_d;
      wr_q        <= wr_d;
      rc_q        <= rc_d;
      mrd_q       <= mrd_d;
      gap_q       <= gap_d;
      mode_set_q  <= mode_set_d;
      cl3_q       <= cl3_d;
      nref_q      <= nref_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      code_q      <= code_d;
      s1_vld_q    <= w_rd_go;
      s2_vld_q    <= s1_vld_q;
      dq_oe_q     <= w_out_vld;
      dq_q        <= w_out_vld ? w_out_data : '0;
    end
  end

  assign sdram_dq_o  = dq_q;
  assign sdram_dq_oe = dq_oe_q;
  assign init_done   = init_done_q;
  assign err         = err_q;
  assign err_code    = code_q;

endmodule
`default_nettype wire
